// File: rtl/data_mem_ctrl_if.sv
// Request/acknowledge bus between the control unit and the data memory
// controller. The control unit is the master; the memory controller is the
// slave and reports completion, errors and busy status back.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              req;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req,
    output op,
    output addr,
    output wdata,
    input  rdata,
    input  ack,
    input  err,
    input  busy
  );

  modport slave (
    input  req,
    input  op,
    input  addr,
    input  wdata,
    output rdata,
    output ack,
    output err,
    output busy
  );

endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory for the 8-bit processor with a req/ack handshake,
// a programmable number of wait states, a two-word preload applied on reset,
// an atomic read-modify-write add, and error reporting for the illegal op.
// The control unit stalls while busy is high and advances on the ack pulse.
module data_mem_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter int                WAIT_CYCLES = 1,   // legal range 1..15
  parameter logic [ADDR_W-1:0] INIT_A0     = ADDR_W'(1),
  parameter logic [DATA_W-1:0] INIT_D0     = DATA_W'(8'h0F),
  parameter logic [ADDR_W-1:0] INIT_A1     = ADDR_W'(3),
  parameter logic [DATA_W-1:0] INIT_D1     = DATA_W'(8'h09)
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RMW     = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

  // Handshake FSM, wait-state counter, memory array and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      // NOTE: the memory array is deliberately reset: software expects a
      // known image after reset. The preload writes come after the clear so
      // they override it, and INIT_D1 wins if both preload addresses match.
      mem          <= '{default: '0};
      mem[INIT_A0] <= INIT_D0;
      mem[INIT_A1] <= INIT_D1;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.req) begin
            op_q     <= op_t'(bus.op);
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            case (op_q)
              OP_READ:  rdata_q <= mem[addr_q];
              OP_WRITE: mem[addr_q] <= wdata_q;
              OP_RMW: begin
                // NOTE: non-blocking assignment means the right-hand side
                // below still sees the old word, so rdata gets the pre-add
                // value while the sum is written back on the same edge.
                rdata_q     <= mem[addr_q];
                mem[addr_q] <= mem[addr_q] + wdata_q;
              end
              default: ;  // illegal op: memory and rdata untouched
            endcase
            ack_q <= 1'b1;
            err_q <= (op_q == OP_ILLEGAL);
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        ST_RESP: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. Two instances are exercised, one
// with WAIT_CYCLES=1 (sel 0) and one with WAIT_CYCLES=4 (sel 1). A small
// memory model computes expected results when a request is driven and pushes
// them onto a scoreboard queue; they are popped when the DUT pulses ack.
module tb_data_mem_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  data_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mdl_mem [2][16];
  logic [DW-1:0] mdl_rd  [2];

  function automatic int wcyc(input int sel);
    return (sel == 0) ? 1 : 4;
  endfunction

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus1.ack : bus4.ack;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus1.err : bus4.err;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus1.busy : bus4.busy;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int sel);
    return (sel == 0) ? bus1.rdata : bus4.rdata;
  endfunction

  task automatic drive(input int sel, input logic rq, input logic [1:0] o,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (sel == 0) begin
      bus1.req = rq; bus1.op = o; bus1.addr = a; bus1.wdata = wd;
    end else begin
      bus4.req = rq; bus4.op = o; bus4.addr = a; bus4.wdata = wd;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mdl_mem[d][i] = '0;
      mdl_mem[d][1] = 8'h0F;
      mdl_mem[d][3] = 8'h09;
      mdl_rd[d]     = '0;
    end
  endtask

  // Apply one operation to the model and queue its expected response.
  task automatic model_push(input int sel, input logic [1:0] o,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
    exp_t e;
    e.err = 1'b0;
    case (o)
      2'b00: mdl_rd[sel] = mdl_mem[sel][a];
      2'b01: mdl_mem[sel][a] = wd;
      2'b10: begin
        mdl_rd[sel]     = mdl_mem[sel][a];
        mdl_mem[sel][a] = mdl_mem[sel][a] + wd;
      end
      default: e.err = 1'b1;
    endcase
    e.rdata = mdl_rd[sel];
    sb.push_back(e);
  endtask

  // One isolated transaction: request, wait for ack, compare with the
  // scoreboard, check latency and that ack/err/busy drop the cycle after.
  task automatic access(input int sel, input logic [1:0] o,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output logic [DW-1:0] seen);
    exp_t e;
    int   lat;
    logic got;
    got  = 1'b0;
    lat  = 0;
    seen = 'x;
    @(negedge clk);
    model_push(sel, o, a, wd);
    drive(sel, 1'b1, o, a, wd);
    for (int j = 1; j <= 40 && !got; j++) begin
      @(negedge clk);
      if (j == 1) begin
        drive(sel, 1'b0, 2'b00, '0, '0);
        n_checks++;
        if (get_busy(sel) !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_after_accept sel=%0d: got %b expected 1", sel, get_busy(sel));
        end
      end
      if (get_ack(sel) === 1'b1) begin
        got = 1'b1;
        lat = j;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_timeout sel=%0d op=%0d addr=%0d: no ack within 40 cycles", sel, o, a);
      sb.delete();
    end else begin
      e    = sb.pop_front();
      seen = get_rdata(sel);
      n_checks++;
      if (seen !== e.rdata) begin
        n_fail++;
        $display("FAIL rdata sel=%0d op=%0d addr=%0d: got %h expected %h", sel, o, a, seen, e.rdata);
      end
      n_checks++;
      if (get_err(sel) !== e.err) begin
        n_fail++;
        $display("FAIL err_with_ack sel=%0d op=%0d: got %b expected %b", sel, o, get_err(sel), e.err);
      end
      n_checks++;
      if (lat != wcyc(sel) + 1) begin
        n_fail++;
        $display("FAIL ack_latency sel=%0d: got %0d expected %0d", sel, lat, wcyc(sel) + 1);
      end
      @(negedge clk);
      n_checks++;
      if (get_ack(sel) !== 1'b0 || get_err(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
        n_fail++;
        $display("FAIL after_ack sel=%0d: got ack=%b err=%b busy=%b expected 0 0 0",
                 sel, get_ack(sel), get_err(sel), get_busy(sel));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (get_rdata(s) !== 8'h00 || get_ack(s) !== 1'b0 ||
          get_err(s) !== 1'b0 || get_busy(s) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d: got rdata=%h ack=%b err=%b busy=%b expected 00 0 0 0",
                 s, get_rdata(s), get_ack(s), get_err(s), get_busy(s));
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_preload();
    logic [DW-1:0] v;
    access(0, 2'b00, 4'd1, 8'h00, v);
    n_checks++;
    if (v !== 8'h0F) begin n_fail++; $display("FAIL preload_a1: got %h expected 0f", v); end
    access(0, 2'b00, 4'd3, 8'h00, v);
    n_checks++;
    if (v !== 8'h09) begin n_fail++; $display("FAIL preload_a3: got %h expected 09", v); end
    access(0, 2'b00, 4'd0, 8'h00, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL cleared_a0: got %h expected 00", v); end
    access(0, 2'b00, 4'd15, 8'h00, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL cleared_a15: got %h expected 00", v); end
    access(1, 2'b00, 4'd3, 8'h00, v);
    n_checks++;
    if (v !== 8'h09) begin n_fail++; $display("FAIL preload_a3_w4: got %h expected 09", v); end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] v;
    access(0, 2'b00, 4'd1, 8'h00, v);
    access(0, 2'b01, 4'd7, 8'hA5, v);
    n_checks++;
    if (v !== 8'h0F) begin n_fail++; $display("FAIL rdata_hold_on_write: got %h expected 0f", v); end
    access(0, 2'b00, 4'd7, 8'h00, v);
    n_checks++;
    if (v !== 8'hA5) begin n_fail++; $display("FAIL readback_a7: got %h expected a5", v); end
  endtask

  task automatic test_rmw();
    logic [DW-1:0] v;
    access(0, 2'b10, 4'd1, 8'hF5, v);
    n_checks++;
    if (v !== 8'h0F) begin n_fail++; $display("FAIL rmw_old_value: got %h expected 0f", v); end
    access(0, 2'b00, 4'd1, 8'h00, v);
    n_checks++;
    if (v !== 8'h04) begin n_fail++; $display("FAIL rmw_wrap: got %h expected 04", v); end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] v;
    access(0, 2'b11, 4'd3, 8'hFF, v);
    access(0, 2'b00, 4'd3, 8'h00, v);
    n_checks++;
    if (v !== 8'h09) begin n_fail++; $display("FAIL illegal_no_write: got %h expected 09", v); end
  endtask

  // req held high throughout; inputs only carry a real request on the
  // cycles that precede an acceptance edge and carry junk otherwise.
  task automatic test_back_to_back(input int sel);
    localparam int NREQ = 4;
    logic [1:0]    ops [NREQ];
    logic [DW-1:0] wds [NREQ];
    exp_t          e;
    int            per;
    int            acks;
    ops[0] = 2'b01; wds[0] = 8'h5A;
    ops[1] = 2'b00; wds[1] = 8'h00;
    ops[2] = 2'b10; wds[2] = 8'h10;
    ops[3] = 2'b00; wds[3] = 8'h00;
    per  = wcyc(sel) + 2;
    acks = 0;
    @(negedge clk);
    for (int j = 0; j <= NREQ * per; j++) begin
      if (j > 0 && get_ack(sel) === 1'b1) begin
        acks++;
        n_checks++;
        if (j % per != per - 1) begin
          n_fail++;
          $display("FAIL b2b_ack_timing sel=%0d: ack at cycle %0d, expected cycle mod %0d == %0d",
                   sel, j, per, per - 1);
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_ack sel=%0d: ack at cycle %0d with nothing pending", sel, j);
        end else begin
          e = sb.pop_front();
          if (get_rdata(sel) !== e.rdata || get_err(sel) !== e.err) begin
            n_fail++;
            $display("FAIL b2b_data sel=%0d cycle %0d: got rdata=%h err=%b expected %h %b",
                     sel, j, get_rdata(sel), get_err(sel), e.rdata, e.err);
          end
        end
      end
      if (j == NREQ * per) begin
        drive(sel, 1'b0, 2'b00, '0, '0);
      end else if (j % per == 0) begin
        model_push(sel, ops[j / per], 4'd5, wds[j / per]);
        drive(sel, 1'b1, ops[j / per], 4'd5, wds[j / per]);
      end else begin
        drive(sel, 1'b1, (j % 2 == 1) ? 2'b11 : 2'b01, 4'($urandom_range(15, 0)), 8'hEE);
      end
      if (j < NREQ * per) @(negedge clk);
    end
    n_checks++;
    if (acks != NREQ) begin
      n_fail++;
      $display("FAIL b2b_ack_count sel=%0d: got %0d expected %0d", sel, acks, NREQ);
    end
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (get_busy(sel) !== 1'b0 || get_ack(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle sel=%0d: got busy=%b ack=%b expected 0 0", sel, get_busy(sel), get_ack(sel));
    end
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] v;
    @(negedge clk);
    drive(0, 1'b1, 2'b01, 4'd2, 8'h33);
    @(negedge clk);
    drive(0, 1'b0, 2'b00, '0, '0);
    n_checks++;
    if (get_busy(0) !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_op_busy: got %b expected 1", get_busy(0));
    end
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (get_ack(0) !== 1'b0 || get_busy(0) !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_op_abort cycle %0d: got ack=%b busy=%b expected 0 0", k, get_ack(0), get_busy(0));
      end
    end
    rst_n = 1'b1;
    model_reset();
    access(0, 2'b00, 4'd2, 8'h00, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL aborted_write_a2: got %h expected 00", v); end
    access(0, 2'b00, 4'd1, 8'h00, v);
    n_checks++;
    if (v !== 8'h0F) begin n_fail++; $display("FAIL reload_a1: got %h expected 0f", v); end
  endtask

  initial begin
    drive(0, 1'b0, 2'b00, '0, '0);
    drive(1, 1'b0, 2'b00, '0, '0);
    test_reset();
    test_preload();
    test_write_read();
    test_rmw();
    test_illegal();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
